// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//
// Two-master arbiter for the shared slave bus.
//    m0 = external host (default / park owner)
//    m1 = DMA controller
//
// Ownership is held in a registered two-state FSM (GNT0 / GNT1).
// The grants, m_sel and the arb_switch pulse all come from flops.
// When idle, the bus parks on m0.
//
// Optional build macro: ARB_HOLD_LIMIT_EN
//    defined   : a contention counter caps how long one owner can keep the
//                bus while the other master is waiting (MAX_HOLD cycles)
//    undefined : no counter; the owner keeps the bus until it drops its
//                request, and hold_cnt reads as zero
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             m0_req,
   input  logic             m1_req,
   output logic             m0_grant,
   output logic             m1_grant,
   output logic             m_sel,
   output logic             arb_switch,
   output logic [CNT_W-1:0] hold_cnt
);

   typedef enum logic {
      GNT0 = 1'b0,
      GNT1 = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   // Set when the current owner has used up its contended cycles and the
   // other master is still waiting; forces a hand-over at the next edge.
   logic   expiry;

`ifdef ARB_HOLD_LIMIT_EN

   // Last count value before a forced hand-over.
   // The owner gets counts 0 .. MAX_HOLD-1, i.e. exactly MAX_HOLD
   // contended cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;
   logic             owner_req;
   logic             other_req;

   // Re-label the two request lines as "owner" and "challenger".
   // This lets the counter logic stay the same for both states.
   always_comb begin
      owner_req = m0_req;
      other_req = m1_req;
      if (state == GNT1) begin
         owner_req = m1_req;
         other_req = m0_req;
      end
   end

   assign expiry = other_req && (cnt_q == CNT_LAST);

   // Counter rules:
   //    - restart on any ownership change
   //    - restart when nobody is waiting
   //    - count up while both masters request, saturating at CNT_LAST
   always_comb begin
      cnt_next = cnt_q;
      if (state_next != state) begin
         cnt_next = '0;
      end else if (!other_req) begin
         cnt_next = '0;
      end else if (owner_req) begin
         if (cnt_q != CNT_LAST) begin
            cnt_next = cnt_q + 1'b1;
         end
      end
   end

   // Contention counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_next;
      end
   end

   assign hold_cnt = cnt_q;

`else

   // Without the hold limit, nobody is ever pre-empted.
   assign expiry   = 1'b0;
   assign hold_cnt = '0;

`endif

   // Next-state logic.
   // A waiting master only takes the bus from a still-requesting owner on
   // hold expiry. Losing the owner's request hands the bus over (or parks
   // it on m0).
   always_comb begin
      state_next = state;
      case (state)
         GNT0: begin
            if (m1_req && (!m0_req || expiry)) begin
               state_next = GNT1;
            end
         end
         GNT1: begin
            if (!m1_req || (m0_req && expiry)) begin
               state_next = GNT0;
            end
         end
         default: begin
            state_next = GNT0;
         end
      endcase
   end

   // State and output registers.
   // The grants are registered straight from the next state, so they never
   // decode through combinational logic. arb_switch flags the first cycle
   // of a new owner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= GNT0;
         m0_grant   <= 1'b1;
         m1_grant   <= 1'b0;
         arb_switch <= 1'b0;
      end else begin
         state      <= state_next;
         m0_grant   <= (state_next == GNT0);
         m1_grant   <= (state_next == GNT1);
         arb_switch <= (state_next != state);
      end
   end

   assign m_sel = m1_grant;

`ifndef SYNTHESIS

   // Grants must be one-hot and track the FSM. The parameters must fit the
   // counter.
   a_grant_onehot : assert property (@(posedge clk) disable iff (!reset_n)
      (m0_grant ^ m1_grant) && (m1_grant == (state == GNT1)));

   a_param_range : assert property (@(posedge clk)
      (MAX_HOLD >= 1) && (MAX_HOLD <= 255) && ((MAX_HOLD >> CNT_W) == 0));

`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
//
// Directed bench for bus_rr_arbiter.
// A vector table covers basic ownership moves. Hand-written sequences cover
// async reset, request timing, contention, counter clearing and (with
// ARB_HOLD_LIMIT_EN) per-cycle alternation.
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 8;

   logic             clk;
   logic             reset_n;
   logic             m0_req;
   logic             m1_req;
   logic             m0_grant;
   logic             m1_grant;
   logic             m_sel;
   logic             arb_switch;
   logic [CNT_W-1:0] hold_cnt;

   int vec_count;
   int err_count;

   bus_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .m0_req     (m0_req),
      .m1_req     (m1_req),
      .m0_grant   (m0_grant),
      .m1_grant   (m1_grant),
      .m_sel      (m_sel),
      .arb_switch (arb_switch),
      .hold_cnt   (hold_cnt)
   );

`ifdef ARB_HOLD_LIMIT_EN
   logic             alt_m0_req;
   logic             alt_m1_req;
   logic             alt_m0_grant;
   logic             alt_m1_grant;
   logic             alt_m_sel;
   logic             alt_arb_switch;
   logic [CNT_W-1:0] alt_hold_cnt;

   bus_rr_arbiter #(.MAX_HOLD(1), .CNT_W(CNT_W)) dut_alt (
      .clk        (clk),
      .reset_n    (reset_n),
      .m0_req     (alt_m0_req),
      .m1_req     (alt_m1_req),
      .m0_grant   (alt_m0_grant),
      .m1_grant   (alt_m1_grant),
      .m_sel      (alt_m_sel),
      .arb_switch (alt_arb_switch),
      .hold_cnt   (alt_hold_cnt)
   );
`endif

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       m0;
      logic       m1;
      logic       g0;
      logic       g1;
      logic       sw;
      logic [7:0] cnt_lim;
   } vec_t;

   vec_t vecs[13];

   // Drive requests at the negedge, let one posedge sample them, and
   // return at the following negedge, ready for checking.
   task automatic apply_stimulus(input logic r0, input logic r1);
      m0_req = r0;
      m1_req = r1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_output(input string name,
                               input logic a_g0, input logic a_g1,
                               input logic a_sel, input logic a_sw,
                               input logic [7:0] a_cnt,
                               input logic e_g0, input logic e_g1,
                               input logic e_sw, input logic [7:0] e_cnt);
      vec_count++;
      if (a_g0 !== e_g0 || a_g1 !== e_g1 || a_sel !== e_g1 ||
          a_sw !== e_sw || a_cnt !== e_cnt) begin
         err_count++;
         $display("[TB] FAIL %s: got g0=%b g1=%b sel=%b sw=%b cnt=%0d, want g0=%b g1=%b sel=%b sw=%b cnt=%0d",
                  name, a_g0, a_g1, a_sel, a_sw, a_cnt,
                  e_g0, e_g1, e_g1, e_sw, e_cnt);
      end
   endtask

   task automatic check_main(input string name, input logic e_g0,
                             input logic e_g1, input logic e_sw,
                             input logic [7:0] e_cnt);
      check_output(name, m0_grant, m1_grant, m_sel, arb_switch, hold_cnt,
                   e_g0, e_g1, e_sw, e_cnt);
   endtask

   // Two idle cycles to park the bus on m0 with a cleared counter.
   task automatic settle();
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
   endtask

   initial begin
      vec_count = 0;
      err_count = 0;
      reset_n   = 1'b0;
      m0_req    = 1'b0;
      m1_req    = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      alt_m0_req = 1'b0;
      alt_m1_req = 1'b0;
`endif

      // Each entry: inputs sampled at one edge, then the outputs after it.
      // cnt_lim is the hold count with the limit built in (MAX_HOLD=4).
      vecs[0]  = '{"idle_park",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{"m1_take",       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
      vecs[2]  = '{"m1_hold",       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[3]  = '{"m1_contend",    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
      vecs[4]  = '{"m1_release",    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
      vecs[5]  = '{"m0_contend1",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[6]  = '{"m0_contend2",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
      vecs[7]  = '{"both_idle",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{"m1_take2",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
      vecs[9]  = '{"both_low_park", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
      vecs[10] = '{"m0_only",       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[11] = '{"m1_take3",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
      vecs[12] = '{"release_race",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};

      // Reset state.
      repeat (2) @(negedge clk);
      check_main("reset_state", 1'b1, 1'b0, 1'b0, 8'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < 13; i++) begin
         apply_stimulus(vecs[i].m0, vecs[i].m1);
         check_main(vecs[i].name, vecs[i].g0, vecs[i].g1, vecs[i].sw,
                    HOLD_EN ? vecs[i].cnt_lim : 8'd0);
      end

      // Async reset in the middle of an m1 grant, with m1_req held high.
      apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1);
      check_main("pre_reset_gnt1", 1'b0, 1'b1, 1'b0, 8'd0);
      #2 reset_n = 1'b0;
      #1 check_main("async_reset", 1'b1, 1'b0, 1'b0, 8'd0);
      @(posedge clk);
      @(negedge clk);
      check_main("reset_held", 1'b1, 1'b0, 1'b0, 8'd0);
      reset_n = 1'b1;
      #1 check_main("reset_release", 1'b1, 1'b0, 1'b0, 8'd0);
      @(posedge clk);
      @(negedge clk);
      check_main("post_reset_take", 1'b0, 1'b1, 1'b1, 8'd0);

      // Single requester: m1 requests during cycles 5..9 only.
      settle();
      for (int c = 0; c < 15; c++) begin
         logic want_g1;
         want_g1 = (c >= 5) && (c < 10);
         apply_stimulus(1'b0, want_g1);
         check_main($sformatf("single_c%0d", c), !want_g1, want_g1,
                    (c == 5) || (c == 10), 8'd0);
      end

      // Contention with m0 as owner.
      apply_stimulus(1'b1, 1'b0);
      check_main("contend_owner", 1'b1, 1'b0, 1'b0, 8'd0);
      if (HOLD_EN) begin
         for (int k = 1; k <= 4; k++) begin
            apply_stimulus(1'b1, 1'b1);
            check_main($sformatf("hold_edge%0d", k), k != 4, k == 4, k == 4,
                       (k < 4) ? 8'(k) : 8'd0);
         end
      end else begin
         for (int k = 1; k <= 100; k++) begin
            apply_stimulus(1'b1, 1'b1);
            check_main($sformatf("nohold_edge%0d", k), 1'b1, 1'b0, 1'b0,
                       8'd0);
         end
      end

      // Counter clear: two contended cycles, one quiet cycle, then count
      // again from zero.
      settle();
      apply_stimulus(1'b1, 1'b0);
      check_main("clr_owner", 1'b1, 1'b0, 1'b0, 8'd0);
      apply_stimulus(1'b1, 1'b1);
      check_main("clr_cnt1", 1'b1, 1'b0, 1'b0, HOLD_EN ? 8'd1 : 8'd0);
      apply_stimulus(1'b1, 1'b1);
      check_main("clr_cnt2", 1'b1, 1'b0, 1'b0, HOLD_EN ? 8'd2 : 8'd0);
      apply_stimulus(1'b1, 1'b0);
      check_main("clr_quiet", 1'b1, 1'b0, 1'b0, 8'd0);
      apply_stimulus(1'b1, 1'b1);
      check_main("clr_recnt1", 1'b1, 1'b0, 1'b0, HOLD_EN ? 8'd1 : 8'd0);
      apply_stimulus(1'b1, 1'b1);
      check_main("clr_recnt2", 1'b1, 1'b0, 1'b0, HOLD_EN ? 8'd2 : 8'd0);
      apply_stimulus(1'b1, 1'b1);
      check_main("clr_recnt3", 1'b1, 1'b0, 1'b0, HOLD_EN ? 8'd3 : 8'd0);
      apply_stimulus(1'b1, 1'b1);
      check_main("clr_expire", !HOLD_EN, HOLD_EN, HOLD_EN, 8'd0);

`ifdef ARB_HOLD_LIMIT_EN
      // MAX_HOLD=1: ownership alternates every cycle under full contention.
      alt_m0_req = 1'b1;
      alt_m1_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_output($sformatf("alt_edge%0d", k), alt_m0_grant, alt_m1_grant,
                      alt_m_sel, alt_arb_switch, alt_hold_cnt,
                      (k % 2) == 0, (k % 2) == 1, 1'b1, 8'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count,
               err_count);
      $finish;
   end

endmodule
